// File: rtl/ni_pkg.sv
// Shared types and constants for the TDM injection scheduler.
// Flit layout: {addr[31:16], data[15:0]} as packed by the network interface.
package ni_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int DEF_DSIZE     = 32;
   localparam int DEF_SLOT_BITS = 3;
   localparam int DEF_SLOT_LEN  = 4;

   localparam int ADDR_MSB = 31;
   localparam int ADDR_LSB = 16;
   localparam int DATA_MSB = 15;
   localparam int DATA_LSB = 0;

   function automatic logic [ADDR_MSB-ADDR_LSB:0] flit_addr(input logic [DEF_DSIZE-1:0] f);
      return f[ADDR_MSB:ADDR_LSB];
   endfunction

   function automatic logic [DATA_MSB-DATA_LSB:0] flit_data(input logic [DEF_DSIZE-1:0] f);
      return f[DATA_MSB:DATA_LSB];
   endfunction

endpackage

// File: rtl/ni_tdm_scheduler_if.sv
// FIFO-read and router-link signals of the TDM scheduler, grouped as one bundle.
// Link handshake: a flit transfers on the rising edge where link_valid and link_ready are both
// high; link_valid never depends on link_ready and link_data is stable while link_valid is high.
interface ni_tdm_scheduler_if #(
   parameter int DSIZE = ni_pkg::DEF_DSIZE
);
   logic             fifo_empty;
   logic             fifo_rd_en;
   logic [DSIZE-1:0] fifo_rd_data;
   logic             link_valid;
   logic [DSIZE-1:0] link_data;
   logic             link_ready;

   modport master (
      input  fifo_empty, fifo_rd_data, link_ready,
      output fifo_rd_en, link_valid, link_data
   );

   modport slave (
      output fifo_empty, fifo_rd_data, link_ready,
      input  fifo_rd_en, link_valid, link_data
   );
endinterface

// File: rtl/tdm_slot_counter.sv
// Free-running TDM time base: cycle-in-slot counter, slot index and slot/period markers.
module tdm_slot_counter
   import ni_pkg::*;
#(
   parameter int SLOT_BITS = DEF_SLOT_BITS,
   parameter int SLOT_LEN  = DEF_SLOT_LEN
) (
   input  logic                        clk,
   input  logic                        reset,
   output logic [$clog2(SLOT_LEN)-1:0] cyc_cnt,
   output logic [SLOT_BITS-1:0]        slot_idx,
   output logic                        slot_end,
   output logic                        period_end,
   output logic                        period_start
);
   localparam int                   CW        = $clog2(SLOT_LEN);
   localparam logic [CW-1:0]        CYC_LAST  = CW'(SLOT_LEN - 1);
   localparam logic [SLOT_BITS-1:0] SLOT_LAST = '1;

   logic [CW-1:0]        r_cyc;
   logic [SLOT_BITS-1:0] r_slot;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cyc  <= '0;
         r_slot <= '0;
      end else if (slot_end) begin
         r_cyc  <= '0;
         r_slot <= r_slot + SLOT_BITS'(1);
      end else begin
         r_cyc  <= r_cyc + CW'(1);
      end
   end

   assign cyc_cnt      = r_cyc;
   assign slot_idx     = r_slot;
   assign slot_end     = (r_cyc == CYC_LAST);
   assign period_end   = slot_end && (r_slot == SLOT_LAST);
   assign period_start = (r_cyc == '0) && (r_slot == '0);
endmodule

// File: rtl/ni_tdm_scheduler.sv
// TDM injection scheduler: pops at most one flit per owned slot from the NI write FIFO and
// offers it on the router link, holding a missed flit until the next owned slot.
module ni_tdm_scheduler
   import ni_pkg::*;
#(
   parameter int                         DSIZE      = DEF_DSIZE,
   parameter int                         SLOT_BITS  = DEF_SLOT_BITS,
   parameter int                         SLOT_LEN   = DEF_SLOT_LEN,
   parameter logic [(1<<SLOT_BITS)-1:0]  RESET_MASK = 8'h01,
   parameter int                         CNT_W      = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cfg_we,
   input  logic [(1<<SLOT_BITS)-1:0]   cfg_slot_mask,
   ni_tdm_scheduler_if.master          bus,
   output logic [SLOT_BITS-1:0]        slot_idx,
   output logic                        period_start,
   output logic [CNT_W-1:0]            sent_count,
   output state_t                      dbg_state
);
   localparam int            NSLOTS   = 1 << SLOT_BITS;
   localparam int            CW       = $clog2(SLOT_LEN);
   localparam logic [CW-1:0] POP_LAST = CW'(SLOT_LEN - 3);

   logic [CW-1:0]     w_cyc;
   logic              w_slot_end;
   logic              w_period_end;
   logic [NSLOTS-1:0] r_active;
   logic [NSLOTS-1:0] r_shadow;
   logic              r_sent_slot;
   state_t            r_state;
   logic [DSIZE-1:0]  r_flit;
   logic [CNT_W-1:0]  r_sent_cnt;

   tdm_slot_counter #(
      .SLOT_BITS (SLOT_BITS),
      .SLOT_LEN  (SLOT_LEN)
   ) u_slot_counter (
      .clk          (clk),
      .reset        (reset),
      .cyc_cnt      (w_cyc),
      .slot_idx     (slot_idx),
      .slot_end     (w_slot_end),
      .period_end   (w_period_end),
      .period_start (period_start)
   );

   // The pop window stops two cycles before slot end so a fetched flit reaches HOLD in-slot.
   wire w_owned = r_active[slot_idx];
   wire w_pop   = (r_state == IDLE) && w_owned && !r_sent_slot && !bus.fifo_empty &&
                  (w_cyc <= POP_LAST);
   wire w_valid = (r_state == HOLD) && w_owned && !r_sent_slot;
   wire w_hs    = w_valid && bus.link_ready;

   // A write landing in the boundary cycle bypasses the shadow so it is not lost for a period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shadow <= RESET_MASK;
         r_active <= RESET_MASK;
      end else begin
         if (cfg_we)       r_shadow <= cfg_slot_mask;
         if (w_period_end) r_active <= cfg_we ? cfg_slot_mask : r_shadow;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_flit      <= '0;
         r_sent_slot <= 1'b0;
         r_sent_cnt  <= '0;
      end else begin
         if (w_slot_end) r_sent_slot <= 1'b0;
         else if (w_hs)  r_sent_slot <= 1'b1;
         if (w_hs) r_sent_cnt <= r_sent_cnt + CNT_W'(1);
         case (r_state)
            IDLE:  if (w_pop) r_state <= FETCH;
            FETCH: begin
               r_flit  <= bus.fifo_rd_data;
               r_state <= HOLD;
            end
            HOLD:  if (w_hs) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.fifo_rd_en = w_pop;
   assign bus.link_valid = w_valid;
   assign bus.link_data  = r_flit;
   assign sent_count     = r_sent_cnt;
   assign dbg_state      = r_state;
endmodule

// File: tb/tb_ni_tdm_scheduler.sv
// Bench for ni_tdm_scheduler: cycle-accurate slot/ownership model compared every cycle,
// plus directed scenarios whose pop/valid/handshake cycles are pinned to literal values.
module tb_ni_tdm_scheduler;
   import ni_pkg::*;

   localparam int SL  = 4;
   localparam int NS  = 8;
   localparam int PER = SL * NS;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_we = 1'b0;
   logic [7:0]  cfg_slot_mask = 8'h00;
   logic [2:0]  slot_idx;
   logic        period_start;
   logic [15:0] sent_count;
   state_t      dbg_state;

   ni_tdm_scheduler_if #(.DSIZE(32)) bus ();

   ni_tdm_scheduler #(
      .DSIZE(32), .SLOT_BITS(3), .SLOT_LEN(SL), .RESET_MASK(8'h01), .CNT_W(16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cfg_we        (cfg_we),
      .cfg_slot_mask (cfg_slot_mask),
      .bus           (bus),
      .slot_idx      (slot_idx),
      .period_start  (period_start),
      .sent_count    (sent_count),
      .dbg_state     (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int          checks = 0;
   int          errors = 0;
   logic [31:0] fq[$];
   logic [31:0] m_src[$];
   logic [31:0] exp_q[$];
   int          pop_t[$];
   int          val_t[$];
   int          hs_t[$];
   int          e_q[$];
   logic        env_pop = 1'b0;

   // model state
   int          m_t = 0;
   int          m_rdy_t = 0;
   int          m_hs_slot = -1;
   logic        m_have = 1'b0;
   logic [31:0] m_prev = '0;
   logic [31:0] m_cur = '0;
   logic [15:0] m_cnt = '0;
   logic [7:0]  m_active = 8'h01;
   logic [7:0]  m_shadow = 8'h01;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got %h exp %h", name, m_t, got, exp);
      end
   endtask

   task automatic chk_list(input string name, input int got[$], input int exp[$]);
      logic bad;
      bad = (got.size() != exp.size());
      for (int i = 0; i < got.size() && !bad; i++)
         if (got[i] != exp[i]) bad = 1'b1;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL %s got %p exp %p", name, got, exp);
      end
   endtask

   task automatic set_exp(input int n, input int a = 0, input int b = 0, input int c = 0);
      e_q.delete();
      if (n > 0) e_q.push_back(a);
      if (n > 1) e_q.push_back(b);
      if (n > 2) e_q.push_back(c);
   endtask

   // ---------------- FIFO environment ----------------
   always begin
      @(posedge clk);
      #1;
      if (env_pop) begin
         if (fq.size() > 0) bus.fifo_rd_data = fq.pop_front();
         env_pop = 1'b0;
      end
      bus.fifo_empty = (fq.size() == 0);
   end

   // ---------------- model + compare ----------------
   always @(negedge clk) begin
      int          cyc, gslot, slot;
      logic        owned, sent, e_rd, e_val;
      logic [31:0] e_data;
      if (reset) begin
         chk("rst_rd_en",  32'(bus.fifo_rd_en), 0);
         chk("rst_valid",  32'(bus.link_valid), 0);
         chk("rst_data",   bus.link_data, 0);
         chk("rst_count",  32'(sent_count), 0);
         chk("rst_slot",   32'(slot_idx), 0);
         m_t = 0; m_rdy_t = 0; m_hs_slot = -1; m_have = 1'b0;
         m_prev = '0; m_cur = '0; m_cnt = '0;
         m_active = 8'h01; m_shadow = 8'h01;
         pop_t.delete(); val_t.delete(); hs_t.delete();
         env_pop = 1'b0;
      end else begin
         cyc   = m_t % SL;
         gslot = m_t / SL;
         slot  = gslot % NS;
         owned = m_active[slot];
         sent  = (m_hs_slot == gslot);
         e_rd  = !m_have && owned && !sent && !bus.fifo_empty && (cyc <= SL - 3);
         e_val = m_have && (m_t >= m_rdy_t) && owned && !sent;
         e_data = (m_have && (m_t < m_rdy_t)) ? m_prev : m_cur;

         chk("rd_en",        32'(bus.fifo_rd_en), 32'(e_rd));
         chk("link_valid",   32'(bus.link_valid), 32'(e_val));
         chk("link_data",    bus.link_data, e_data);
         chk("slot_idx",     32'(slot_idx), slot);
         chk("period_start", 32'(period_start), 32'(m_t % PER == 0));
         chk("sent_count",   32'(sent_count), 32'(m_cnt));

         if (bus.fifo_rd_en) begin
            pop_t.push_back(m_t);
            env_pop = 1'b1;
         end
         if (bus.link_valid) val_t.push_back(m_t);
         if (bus.link_valid && bus.link_ready) begin
            hs_t.push_back(m_t);
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_unexpected t=%0d got %h exp none", m_t, bus.link_data);
            end else begin
               chk("sb_data", bus.link_data, exp_q.pop_front());
            end
         end

         if (e_val && bus.link_ready) begin
            m_cnt++;
            m_hs_slot = gslot;
            m_have = 1'b0;
         end
         if (e_rd) begin
            m_prev  = m_cur;
            m_cur   = (m_src.size() > 0) ? m_src.pop_front() : 32'h0;
            m_have  = 1'b1;
            m_rdy_t = m_t + 2;
         end
         if (cfg_we) m_shadow = cfg_slot_mask;
         if (cyc == SL - 1 && slot == NS - 1) m_active = m_shadow;
         m_t++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic goto(input int c);
      int guard;
      guard = 0;
      while (m_t != c) begin
         @(posedge clk);
         guard++;
         if (guard > 2000) begin
            checks++; errors++;
            $display("FAIL goto_timeout got %0d exp %0d", m_t, c);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "cycle target not reached");
         end
      end
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      cfg_we = 1'b0;
      cfg_slot_mask = 8'h00;
      bus.link_ready = 1'b1;
      fq.delete(); m_src.delete(); exp_q.delete();
      bus.fifo_empty = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic push_flit(input logic [31:0] d);
      fq.push_back(d);
      m_src.push_back(d);
      exp_q.push_back(d);
      bus.fifo_empty = 1'b0;
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      bus.fifo_empty = 1'b1;
      bus.fifo_rd_data = '0;
      bus.link_ready = 1'b1;

      // single flit, mask 01
      do_reset();
      push_flit(32'hA5A5AAAA);
      goto(40);
      set_exp(1, 0);    chk_list("t1_pop", pop_t, e_q);
      set_exp(1, 2);    chk_list("t1_valid", val_t, e_q);
      set_exp(1, 2);    chk_list("t1_hs", hs_t, e_q);
      chk("t1_count", 32'(sent_count), 1);
      chk("t1_drained", exp_q.size(), 0);

      // mask 05 loaded in the boundary cycle: slots 0 and 2 from cycle 32
      do_reset();
      goto(31);
      cfg_we = 1'b1; cfg_slot_mask = 8'h05;
      push_flit(32'h12345678);
      push_flit(32'h9ABCDEF0);
      goto(32);
      cfg_we = 1'b0;
      goto(50);
      set_exp(2, 32, 40); chk_list("t2_pop", pop_t, e_q);
      set_exp(2, 34, 42); chk_list("t2_valid", val_t, e_q);
      chk("t2_count", 32'(sent_count), 2);

      // backpressure for all of slot 0, retried in the next period without re-pop
      do_reset();
      bus.link_ready = 1'b0;
      push_flit(32'hCAFE0001);
      goto(32);
      bus.link_ready = 1'b1;
      goto(40);
      set_exp(1, 0);         chk_list("t3_pop", pop_t, e_q);
      set_exp(3, 2, 3, 32);  chk_list("t3_valid", val_t, e_q);
      set_exp(1, 32);        chk_list("t3_hs", hs_t, e_q);
      chk("t3_count", 32'(sent_count), 1);

      // reconfiguration to mask 02 mid-period
      do_reset();
      push_flit(32'h11110001);
      push_flit(32'h22220002);
      goto(5);
      cfg_we = 1'b1; cfg_slot_mask = 8'h02;
      goto(6);
      cfg_we = 1'b0;
      goto(50);
      set_exp(2, 0, 36); chk_list("t4_pop", pop_t, e_q);
      set_exp(2, 2, 38); chk_list("t4_valid", val_t, e_q);

      // FIFO fills after the pop window closes
      do_reset();
      goto(2);
      push_flit(32'h0BAD0F00);
      goto(40);
      set_exp(1, 32); chk_list("t5_pop", pop_t, e_q);
      set_exp(1, 34); chk_list("t5_valid", val_t, e_q);

      // two queued flits, one slot owned: one flit per slot
      do_reset();
      push_flit(32'hAAAA5555);
      push_flit(32'h5555AAAA);
      goto(40);
      set_exp(2, 0, 32); chk_list("t6_pop", pop_t, e_q);
      set_exp(2, 2, 34); chk_list("t6_valid", val_t, e_q);

      // reset while a flit is held
      do_reset();
      bus.link_ready = 1'b0;
      push_flit(32'hDEADBEEF);
      goto(3);
      set_exp(1, 0); chk_list("t7_pop_pre", pop_t, e_q);
      set_exp(1, 2); chk_list("t7_valid_pre", val_t, e_q);
      reset = 1'b1;
      #1;
      chk("t7_async_valid", 32'(bus.link_valid), 0);
      chk("t7_async_data",  bus.link_data, 0);
      chk("t7_async_rd_en", 32'(bus.fifo_rd_en), 0);
      chk("t7_async_count", 32'(sent_count), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      bus.link_ready = 1'b1;
      goto(40);
      set_exp(0); chk_list("t7_pop_post", pop_t, e_q);
      chk_list("t7_valid_post", val_t, e_q);
      chk_list("t7_hs_post", hs_t, e_q);
      chk("t7_dropped", exp_q.size(), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      checks++; errors++;
      $display("FAIL watchdog got timeout exp finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end
endmodule
